// File: rtl/exec_mem_stage_if.sv
// Upstream control/operand bundle, data-memory port and writeback port of the
// execute/memory stage, gathered into one interface.
interface exec_mem_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
);
  // Upstream bundle
  logic              valid_in;
  logic              in_ready;
  logic              mem_read;
  logic              mem_write;
  logic              wb;
  logic [1:0]        alu_operation;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [REG_W-1:0]  dest;
  // Data memory
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  // Writeback and status
  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              ctrl_err;

  // Stage side
  modport slave (
    input  valid_in, mem_read, mem_write, wb, alu_operation, op_a, op_b, dest,
    input  dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_en, wb_reg, wb_data, ctrl_err
  );

  // Control unit / memory / register file side
  modport master (
    output valid_in, mem_read, mem_write, wb, alu_operation, op_a, op_b, dest,
    output dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_en, wb_reg, wb_data, ctrl_err
  );
endinterface

// File: rtl/exec_mem_stage.sv
// Execute/memory pipeline stage: a small ALU plus a single outstanding data
// memory access, followed by a one-cycle writeback pulse.
module exec_mem_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input logic              clk,
  input logic              rst_n,
  exec_mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StMem, StWb} state_e;

  state_e            state_q;
  logic              is_store_q;
  logic [REG_W-1:0]  pend_reg_q;
  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [DATA_W-1:0] dmem_addr_q;
  logic [DATA_W-1:0] dmem_wdata_q;
  logic              wb_en_q;
  logic [REG_W-1:0]  wb_reg_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              ctrl_err_q;

  logic              ready;
  logic              xfer;
  logic              is_load;
  logic              is_store;
  logic              illegal;
  logic [DATA_W-1:0] alu_res;

  assign ready    = (state_q != StMem);
  assign xfer     = bus.valid_in && ready;
  assign is_load  = bus.mem_read && !bus.mem_write;
  assign is_store = bus.mem_write && !bus.mem_read;
  assign illegal  = bus.mem_read && bus.mem_write;

  // ALU: add wraps (carry dropped), not inverts op_a, codes 2/3 pass op_a through.
  always_comb begin
    alu_res = bus.op_a;
    unique case (bus.alu_operation)
      2'd0:    alu_res = bus.op_a + bus.op_b;
      2'd1:    alu_res = ~bus.op_a;
      default: alu_res = bus.op_a;
    endcase
  end

  // Stage FSM with all outputs registered; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      pend_reg_q   <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_en_q      <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      ctrl_err_q   <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      unique case (state_q)
        StIdle, StWb: begin
          state_q <= StIdle;
          if (xfer) begin
            if (illegal) begin
              // Both memory bits set: treat as a NOP, no writeback, flag sticks.
              ctrl_err_q <= 1'b1;
            end else if (is_load || is_store) begin
              state_q      <= StMem;
              is_store_q   <= is_store;
              pend_reg_q   <= bus.dest;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store;
              dmem_addr_q  <= bus.op_a;
              dmem_wdata_q <= bus.op_b;
            end else if (bus.wb) begin
              state_q   <= StWb;
              wb_en_q   <= 1'b1;
              wb_reg_q  <= bus.dest;
              wb_data_q <= alu_res;
            end
          end
        end
        StMem: begin
          // Request is always high here, so ack is only honoured while requesting.
          if (bus.dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (is_store_q) begin
              state_q <= StIdle;
            end else begin
              // Loads always write back the returned data.
              state_q   <= StWb;
              wb_en_q   <= 1'b1;
              wb_reg_q  <= pend_reg_q;
              wb_data_q <= bus.dmem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = ready;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_reg     = wb_reg_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.ctrl_err   = ctrl_err_q;

endmodule

// File: tb/tb_exec_mem_stage.sv
// Bench for exec_mem_stage: directed scenarios plus randomized traffic checked
// against a transaction-level reference model.
module tb_exec_mem_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  exec_mem_stage_if #(.DATA_W(16), .REG_W(3)) bus ();

  exec_mem_stage #(.DATA_W(16), .REG_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from plain arithmetic on integers.
  function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int s;
    if (op == 2'd0)      s = (int'(a) + int'(b)) % 65536;
    else if (op == 2'd1) s = 65535 - int'(a);
    else                 s = int'(a);
    return 16'(s);
  endfunction

  task automatic drive(input logic v, input logic mr, input logic mw, input logic w,
                       input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    bus.valid_in      = v;
    bus.mem_read      = mr;
    bus.mem_write     = mw;
    bus.wb            = w;
    bus.alu_operation = op;
    bus.op_a          = a;
    bus.op_b          = b;
    bus.dest          = d;
  endtask

  task automatic idle_cycle();
    bus.valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_req got %b want 0", bus.dmem_req); end
    n_cmp++; if (bus.dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_we got %b want 0", bus.dmem_we); end
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %b want 0", bus.wb_en); end
    n_cmp++; if (bus.ctrl_err !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_err got %b want 0", bus.ctrl_err); end
    n_cmp++; if (bus.dmem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_dmem_addr got %h want 0000", bus.dmem_addr); end
    n_cmp++; if (bus.dmem_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_dmem_wdata got %h want 0000", bus.dmem_wdata); end
    n_cmp++; if (bus.wb_data !== 16'h0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0000", bus.wb_data); end
    n_cmp++; if (bus.wb_reg !== 3'd0) begin n_fail++; $display("FAIL reset_wb_reg got %0d want 0", bus.wb_reg); end
    idle_cycle();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_cycle_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    idle_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'hFFFF, 16'h0002, 3'd5);
    @(negedge clk);
    bus.valid_in = 1'b0;
    n_cmp++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL add_wb_en got %b want 1", bus.wb_en); end
    n_cmp++; if (bus.wb_reg !== 3'd5) begin n_fail++; $display("FAIL add_wb_reg got %0d want 5", bus.wb_reg); end
    n_cmp++; if (bus.wb_data !== 16'h0001) begin n_fail++; $display("FAIL add_wb_data got %h want 0001", bus.wb_data); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL add_no_dmem_req got %b want 0", bus.dmem_req); end
    @(negedge clk);
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL add_wb_en_pulse got %b want 0", bus.wb_en); end
    n_cmp++; if (bus.wb_data !== 16'h0001) begin n_fail++; $display("FAIL add_hold_data got %h want 0001", bus.wb_data); end
  endtask

  task automatic test_load();
    idle_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0040, 16'h1234, 3'd3);
    @(negedge clk);
    bus.valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL load_req[%0d] got %b want 1", i, bus.dmem_req); end
      n_cmp++; if (bus.dmem_addr !== 16'h0040) begin n_fail++; $display("FAIL load_addr[%0d] got %h want 0040", i, bus.dmem_addr); end
      n_cmp++; if (bus.dmem_we !== 1'b0) begin n_fail++; $display("FAIL load_we[%0d] got %b want 0", i, bus.dmem_we); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL load_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      if (i == 2) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 16'hBEEF;
      end
      @(negedge clk);
    end
    bus.dmem_ack = 1'b0;
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL load_req_drop got %b want 0", bus.dmem_req); end
    n_cmp++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL load_wb_en got %b want 1", bus.wb_en); end
    n_cmp++; if (bus.wb_data !== 16'hBEEF) begin n_fail++; $display("FAIL load_wb_data got %h want beef", bus.wb_data); end
    n_cmp++; if (bus.wb_reg !== 3'd3) begin n_fail++; $display("FAIL load_wb_reg got %0d want 3", bus.wb_reg); end
    @(negedge clk);
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL load_wb_pulse got %b want 0", bus.wb_en); end
  endtask

  task automatic test_store();
    idle_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0010, 16'h0055, 3'd6);
    @(negedge clk);
    bus.valid_in = 1'b0;
    n_cmp++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL store_req got %b want 1", bus.dmem_req); end
    n_cmp++; if (bus.dmem_we !== 1'b1) begin n_fail++; $display("FAIL store_we got %b want 1", bus.dmem_we); end
    n_cmp++; if (bus.dmem_addr !== 16'h0010) begin n_fail++; $display("FAIL store_addr got %h want 0010", bus.dmem_addr); end
    n_cmp++; if (bus.dmem_wdata !== 16'h0055) begin n_fail++; $display("FAIL store_wdata got %h want 0055", bus.dmem_wdata); end
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL store_req_drop got %b want 0", bus.dmem_req); end
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL store_no_wb got %b want 0", bus.wb_en); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL store_idle_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL store_no_wb_late got %b want 0", bus.wb_en); end
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h00F0, 16'h0000, 3'd1);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_wb got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL b2b_first_en got %b want 1", bus.wb_en); end
    n_cmp++; if (bus.wb_data !== 16'hFF0F) begin n_fail++; $display("FAIL b2b_first_data got %h want ff0f", bus.wb_data); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0001, 16'h0001, 3'd2);
    @(negedge clk);
    bus.valid_in = 1'b0;
    n_cmp++; if (bus.wb_en !== 1'b1) begin n_fail++; $display("FAIL b2b_second_en got %b want 1", bus.wb_en); end
    n_cmp++; if (bus.wb_data !== 16'h0002) begin n_fail++; $display("FAIL b2b_second_data got %h want 0002", bus.wb_data); end
    n_cmp++; if (bus.wb_reg !== 3'd2) begin n_fail++; $display("FAIL b2b_second_reg got %0d want 2", bus.wb_reg); end
    @(negedge clk);
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", bus.wb_en); end
  endtask

  task automatic test_illegal();
    idle_cycle();
    n_cmp++; if (bus.ctrl_err !== 1'b0) begin n_fail++; $display("FAIL illegal_pre_err got %b want 0", bus.ctrl_err); end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0033, 16'h0044, 3'd7);
    @(negedge clk);
    bus.valid_in = 1'b0;
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL illegal_no_req got %b want 0", bus.dmem_req); end
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL illegal_no_wb got %b want 0", bus.wb_en); end
    n_cmp++; if (bus.ctrl_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", bus.ctrl_err); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %b want 1", bus.in_ready); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0003, 16'h0004, 3'd4);
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ctrl_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_sticky got %b want 1", bus.ctrl_err); end
  endtask

  // Each op is applied at a negedge; expectations for the writeback port are
  // derived from the operation semantics alone.
  task automatic test_random();
    logic        exp_en;
    logic [2:0]  exp_reg;
    logic [15:0] exp_data;
    logic        exp_err;
    logic [15:0] a, b, rd;
    logic [2:0]  d;
    logic [1:0]  op;
    logic        w;
    int          kind, lat;
    idle_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000, 3'd0);
    @(negedge clk);
    exp_en = 1'b1; exp_reg = 3'd0; exp_data = 16'hFFFF; exp_err = 1'b1;
    for (int i = 0; i < 60; i++) begin
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b want 1", i, bus.in_ready); end
      n_cmp++; if (bus.wb_en !== exp_en) begin n_fail++; $display("FAIL rnd_wb_en[%0d] got %b want %b", i, bus.wb_en, exp_en); end
      n_cmp++; if (bus.wb_data !== exp_data) begin n_fail++; $display("FAIL rnd_wb_data[%0d] got %h want %h", i, bus.wb_data, exp_data); end
      n_cmp++; if (bus.wb_reg !== exp_reg) begin n_fail++; $display("FAIL rnd_wb_reg[%0d] got %0d want %0d", i, bus.wb_reg, exp_reg); end
      n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_low[%0d] got %b want 0", i, bus.dmem_req); end
      n_cmp++; if (bus.ctrl_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", i, bus.ctrl_err, exp_err); end
      if ($urandom_range(0, 2) == 0) begin
        // Idle gap with a stray ack that must be ignored.
        bus.valid_in = 1'b0;
        bus.dmem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_en = 1'b0;
        bus.dmem_ack = 1'b0;
        n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL rnd_gap_en[%0d] got %b want 0", i, bus.wb_en); end
        n_cmp++; if (bus.wb_data !== exp_data) begin n_fail++; $display("FAIL rnd_gap_hold[%0d] got %h want %h", i, bus.wb_data, exp_data); end
        n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_gap_req[%0d] got %b want 0", i, bus.dmem_req); end
      end
      kind = $urandom_range(0, 9);
      a    = 16'($urandom);
      b    = 16'($urandom);
      d    = 3'($urandom);
      op   = 2'($urandom);
      w    = 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'($urandom_range(0, 1));
      if (kind <= 4) begin
        drive(1'b1, 1'b0, 1'b0, w, op, a, b, d);
        @(negedge clk);
        exp_en = w;
        if (w) begin exp_reg = d; exp_data = ref_alu(op, a, b); end
      end else if (kind == 9) begin
        drive(1'b1, 1'b1, 1'b1, w, op, a, b, d);
        @(negedge clk);
        exp_en = 1'b0; exp_err = 1'b1;
      end else begin
        // kinds 5,6 load (always with wb=1), 7,8 store
        drive(1'b1, kind <= 6, kind >= 7, (kind <= 6) ? 1'b1 : w, op, a, b, d);
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.dmem_ack = 1'b0;
        lat = $urandom_range(0, 3);
        for (int j = 0; j <= lat; j++) begin
          n_cmp++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rnd_mem_req[%0d.%0d] got %b want 1", i, j, bus.dmem_req); end
          n_cmp++; if (bus.dmem_addr !== a) begin n_fail++; $display("FAIL rnd_mem_addr[%0d.%0d] got %h want %h", i, j, bus.dmem_addr, a); end
          n_cmp++; if (bus.dmem_wdata !== b) begin n_fail++; $display("FAIL rnd_mem_wdata[%0d.%0d] got %h want %h", i, j, bus.dmem_wdata, b); end
          n_cmp++; if (bus.dmem_we !== (kind >= 7)) begin n_fail++; $display("FAIL rnd_mem_we[%0d.%0d] got %b want %b", i, j, bus.dmem_we, kind >= 7); end
          n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_mem_ready[%0d.%0d] got %b want 0", i, j, bus.in_ready); end
          n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL rnd_mem_wb[%0d.%0d] got %b want 0", i, j, bus.wb_en); end
          if (j == lat) begin
            rd = 16'($urandom);
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = rd;
          end
          @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        if (kind <= 6) begin exp_en = 1'b1; exp_reg = d; exp_data = rd; end
        else exp_en = 1'b0;
      end
    end
    bus.valid_in = 1'b0;
    n_cmp++; if (bus.wb_en !== exp_en) begin n_fail++; $display("FAIL rnd_last_en got %b want %b", bus.wb_en, exp_en); end
    n_cmp++; if (bus.wb_data !== exp_data) begin n_fail++; $display("FAIL rnd_last_data got %h want %h", bus.wb_data, exp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    idle_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0123, 16'h0000, 3'd2);
    @(negedge clk);
    bus.valid_in = 1'b0;
    n_cmp++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_before got %b want 1", bus.dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_async got %b want 0", bus.dmem_req); end
    n_cmp++; if (bus.ctrl_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err_async got %b want 0", bus.ctrl_err); end
    n_cmp++; if (bus.dmem_addr !== 16'h0) begin n_fail++; $display("FAIL rmid_addr_async got %h want 0000", bus.dmem_addr); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_async got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.wb_en !== 1'b0) begin n_fail++; $display("FAIL rmid_late_ack_wb got %b want 0", bus.wb_en); end
    n_cmp++; if (bus.wb_data !== 16'h0) begin n_fail++; $display("FAIL rmid_late_ack_data got %h want 0000", bus.wb_data); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_after got %b want 0", bus.dmem_req); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 3'd0);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
